// File: rtl/bp_pkg.sv
// bp_pkg: Q8.8 format, FSM states and fixed-point helpers shared by
// the backprop engine and the forward-propagation stages.
package bp_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int ONE  = 1 << FRAC;
  localparam int XW   = 48;

  typedef logic signed [DW-1:0] q_t;
  typedef logic signed [XW-1:0] wide_t;

  typedef enum logic [2:0] {
    IDLE, FETCH_O, CALC_D, RD_W, WR_W, DONE
  } state_t;

  localparam wide_t QMAX = XW'((1 <<< (DW-1)) - 1);
  localparam wide_t QMIN = XW'(-(1 <<< (DW-1)));

  function automatic q_t sat_dw(input wide_t x);
    if (x > QMAX) return q_t'(QMAX);
    if (x < QMIN) return q_t'(QMIN);
    return q_t'(x);
  endfunction

  // Full-width signed product, then floor shift back to Q8.8.
  function automatic wide_t mul_sh(input wide_t a, input wide_t b);
    logic signed [2*XW-1:0] p;
    p = (2*XW)'(a) * (2*XW)'(b);
    return wide_t'(p >>> FRAC);
  endfunction

endpackage

// File: rtl/backward_propagation_if.sv
// backward_propagation_if: external weight-memory port.
// master = training engine, slave = weight RAM (1-cycle read).
interface backward_propagation_if
  import bp_pkg::*;
#(
  parameter int AW = 7
) ();

  logic [AW-1:0] w_addr;
  logic          w_rd_en;
  q_t            w_rdata;
  logic          w_wr_en;
  q_t            w_wdata;

  modport master (
    output w_addr, w_rd_en, w_wr_en, w_wdata,
    input  w_rdata
  );

  modport slave (
    input  w_addr, w_rd_en, w_wr_en, w_wdata,
    output w_rdata
  );

endinterface

// File: rtl/bp_delta_unit.sv
// bp_delta_unit: combinational output-layer error delta.
// o, t: sigmoid output and target (Q8.8); delta: saturated Q8.8.
module bp_delta_unit
  import bp_pkg::*;
(
  input  q_t o,
  input  q_t t,
  output q_t delta
);

  wide_t e;
  wide_t p;

  always_comb begin
    e     = XW'(o) - XW'(t);
    p     = mul_sh(XW'(o), XW'(ONE) - XW'(o));
    delta = sat_dw(mul_sh(e, p));
  end

endmodule

// File: rtl/backward_propagation.sv
// backward_propagation: per-sample output-layer weight update engine.
// Ports: start/lr/busy/done, out_*/hid_* reads, wm weight bus, delta stream.
module backward_propagation
  import bp_pkg::*;
#(
  parameter  int NOUT = 10,
  parameter  int NHID = 10,
  localparam int KW = NOUT > 1 ? $clog2(NOUT) : 1,
  localparam int JW = NHID > 1 ? $clog2(NHID) : 1,
  localparam int AW = (NOUT*NHID) > 1 ? $clog2(NOUT*NHID) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DW-1:0]          lr,
  output logic                   busy,
  output logic                   done,
  output logic [KW-1:0]          out_addr,
  input  q_t                     out_act,
  input  q_t                     out_tgt,
  output logic [JW-1:0]          hid_addr,
  input  q_t                     hid_act,
  backward_propagation_if.master wm,
  output logic                   delta_valid,
  output logic [KW-1:0]          delta_idx,
  output q_t                     delta_out
);

  state_t        state;
  state_t        state_nx;
  logic [KW-1:0] k;
  logic [JW-1:0] j;
  q_t            delta_r;
  q_t            delta_c;
  q_t            w_new;
  wide_t         dw;
  logic          k_last;
  logic          j_last;

  bp_delta_unit u_delta (
    .o     (out_act),
    .t     (out_tgt),
    .delta (delta_c)
  );

  assign k_last = int'(k) == NOUT - 1;
  assign j_last = int'(j) == NHID - 1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = FETCH_O;
      FETCH_O: state_nx = CALC_D;
      CALC_D:  state_nx = RD_W;
      RD_W:    state_nx = WR_W;
      WR_W: begin
        if (!j_last)      state_nx = RD_W;
        else if (!k_last) state_nx = FETCH_O;
        else              state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      j       <= '0;
      delta_r <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) k <= '0;
        CALC_D: begin
          delta_r <= delta_c;
          j       <= '0;
        end
        WR_W: begin
          if (!j_last)      j <= j + JW'(1);
          else if (!k_last) k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // hid_act and w_rdata both land in WR_W, one cycle after RD_W.
  always_comb begin
    dw    = mul_sh(mul_sh(XW'(lr), XW'(delta_r)), XW'(hid_act));
    w_new = sat_dw(XW'(wm.w_rdata) - dw);
  end

  always_comb begin
    busy        = state != IDLE;
    done        = state == DONE;
    wm.w_rd_en  = state == RD_W;
    wm.w_wr_en  = state == WR_W;
    wm.w_wdata  = (state == WR_W) ? w_new : '0;
    delta_valid = (state == RD_W) && (j == '0);
    delta_idx   = delta_valid ? k : '0;
    delta_out   = delta_valid ? delta_r : '0;
  end

  assign out_addr  = k;
  assign hid_addr  = j;
  assign wm.w_addr = AW'(int'(k) * NHID + int'(j));

endmodule

// File: tb/tb_backward_propagation.sv
// tb_backward_propagation: scoreboard bench for a default-size engine
// and a 1x1 engine sharing clock and reset.
module tb_backward_propagation;
  import bp_pkg::*;

  localparam int NO = 10;
  localparam int NH = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; int val; } ent_t;
  ent_t bdq[$];
  ent_t bwq[$];
  ent_t sdq[$];
  ent_t swq[$];

  // default-size DUT
  logic        b_start = 1'b0;
  logic [15:0] b_lr = '0;
  logic        b_busy, b_done, b_dv;
  logic [3:0]  b_out_addr, b_hid_addr, b_didx;
  q_t          b_out_act = '0, b_out_tgt = '0, b_hid_act = '0;
  q_t          b_dout;

  backward_propagation_if #(.AW(7)) ifb ();

  backward_propagation #(.NOUT(NO), .NHID(NH)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .lr(b_lr),
    .busy(b_busy), .done(b_done),
    .out_addr(b_out_addr), .out_act(b_out_act), .out_tgt(b_out_tgt),
    .hid_addr(b_hid_addr), .hid_act(b_hid_act),
    .wm(ifb),
    .delta_valid(b_dv), .delta_idx(b_didx), .delta_out(b_dout)
  );

  // 1x1 DUT
  logic        s_start = 1'b0;
  logic [15:0] s_lr = '0;
  logic        s_busy, s_done, s_dv;
  logic [0:0]  s_out_addr, s_hid_addr, s_didx;
  q_t          s_out_act = '0, s_out_tgt = '0, s_hid_act = '0;
  q_t          s_dout;

  backward_propagation_if #(.AW(1)) ifs ();

  backward_propagation #(.NOUT(1), .NHID(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .lr(s_lr),
    .busy(s_busy), .done(s_done),
    .out_addr(s_out_addr), .out_act(s_out_act), .out_tgt(s_out_tgt),
    .hid_addr(s_hid_addr), .hid_act(s_hid_act),
    .wm(ifs),
    .delta_valid(s_dv), .delta_idx(s_didx), .delta_out(s_dout)
  );

  // memories with 1-cycle read latency
  int o_m[NO];
  int t_m[NO];
  int h_m[NH];
  int w_m[NO*NH];
  int s_o = 0, s_t = 0, s_h = 0, s_w = 0;

  always @(posedge clk) begin
    b_out_act <= q_t'(o_m[int'(b_out_addr) % NO]);
    b_out_tgt <= q_t'(t_m[int'(b_out_addr) % NO]);
    b_hid_act <= q_t'(h_m[int'(b_hid_addr) % NH]);
    if (ifb.w_rd_en) ifb.w_rdata <= q_t'(w_m[int'(ifb.w_addr) % (NO*NH)]);
    if (ifb.w_wr_en) w_m[int'(ifb.w_addr) % (NO*NH)] = int'(ifb.w_wdata);
    s_out_act <= q_t'(s_o);
    s_out_tgt <= q_t'(s_t);
    s_hid_act <= q_t'(s_h);
    if (ifs.w_rd_en) ifs.w_rdata <= q_t'(s_w);
    if (ifs.w_wr_en) s_w = int'(ifs.w_wdata);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic int gdelta(input int o, input int t);
    longint e = longint'(o) - longint'(t);
    longint p = (longint'(o) * longint'(256 - o)) >>> 8;
    return sat16((e * p) >>> 8);
  endfunction

  function automatic int gw(input int w, input int lr, input int d, input int h);
    longint s = (longint'(lr) * longint'(d)) >>> 8;
    longint dw = (s * longint'(h)) >>> 8;
    return sat16(longint'(w) - dw);
  endfunction

  // monitors
  int b_next_rd = 0, b_last_rd = -1, b_wr_cnt = 0, b_dv_cnt = 0;
  int s_cyc = 0;

  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) chk("no_wr_in_reset", int'(ifb.w_wr_en), 0);
    if (b_dv) begin
      b_dv_cnt++;
      if (bdq.size() == 0) begin
        errors++;
        $display("FAIL delta_unexpected idx %0d", b_didx);
      end else begin
        e = bdq.pop_front();
        chk("delta_idx", int'(b_didx), e.idx);
        chk("delta_val", int'(b_dout), e.val);
      end
    end
    if (ifb.w_rd_en) begin
      chk("rd_wr_excl", int'(ifb.w_wr_en), 0);
      chk("rd_addr", int'(ifb.w_addr), b_next_rd);
      b_last_rd = int'(ifb.w_addr);
      b_next_rd++;
    end
    if (ifb.w_wr_en) begin
      b_wr_cnt++;
      chk("wr_after_rd", int'(ifb.w_addr), b_last_rd);
      if (bwq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected addr %0d", ifb.w_addr);
      end else begin
        e = bwq.pop_front();
        chk("wr_addr", int'(ifb.w_addr), e.idx);
        chk("wr_data", int'(ifb.w_wdata), e.val);
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (s_busy) s_cyc++;
    else s_cyc = 0;
    if (s_dv) begin
      chk("s_dv_cycle", s_cyc, 3);
      if (sdq.size() == 0) begin
        errors++;
        $display("FAIL s_delta_unexpected %0d", s_dout);
      end else begin
        e = sdq.pop_front();
        chk("s_delta_idx", int'(s_didx), e.idx);
        chk("s_delta_val", int'(s_dout), e.val);
      end
    end
    if (ifs.w_wr_en) begin
      chk("s_wr_cycle", s_cyc, 4);
      if (swq.size() == 0) begin
        errors++;
        $display("FAIL s_wr_unexpected %0d", ifs.w_wdata);
      end else begin
        e = swq.pop_front();
        chk("s_wr_data", int'(ifs.w_wdata), e.val);
      end
    end
    if (s_done) chk("s_done_cycle", s_cyc, 5);
  end

  task automatic push_pass();
    for (int k = 0; k < NO; k++) begin
      int d = gdelta(o_m[k], t_m[k]);
      bdq.push_back('{k, d});
      for (int j = 0; j < NH; j++)
        bwq.push_back('{k*NH + j, gw(w_m[k*NH + j], int'(b_lr), d, h_m[j])});
    end
  endtask

  task automatic run_b(input int exp_len, input bit mid, input string nm);
    int n = 0;
    int extra = 0;
    b_next_rd = 0;
    b_wr_cnt = 0;
    b_dv_cnt = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (b_busy && n < 400) begin
      n++;
      b_start = (mid && n == 50);
      @(negedge clk);
    end
    b_start = 1'b0;
    chk({nm, "_len"}, n, exp_len);
    repeat (30) begin
      @(negedge clk);
      if (b_busy) extra++;
    end
    chk({nm, "_no_extra"}, extra, 0);
    chk({nm, "_writes"}, b_wr_cnt, NO*NH);
    chk({nm, "_deltas"}, b_dv_cnt, NO);
    chk({nm, "_dq_empty"}, bdq.size(), 0);
    chk({nm, "_wq_empty"}, bwq.size(), 0);
  endtask

  task automatic run_s(input string nm);
    int n = 0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (s_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_len"}, n, 5);
    chk({nm, "_q_empty"}, sdq.size() + swq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int w34_new, w35_old;
    for (int k = 0; k < NO; k++) begin
      o_m[k] = 17 + 26*k;
      t_m[k] = (k % 3 == 0) ? 256 : (k % 3 == 1) ? 0 : 128;
    end
    for (int j = 0; j < NH; j++) h_m[j] = -300 + 71*j;
    for (int a = 0; a < NO*NH; a++) w_m[a] = (a * 613) % 65536 - 32768;
    w_m[0] = 32767;
    w_m[99] = -32768;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(b_busy), 0);
    chk("rst_done", int'(b_done), 0);
    chk("rst_rd_en", int'(ifb.w_rd_en), 0);
    chk("rst_wr_en", int'(ifb.w_wr_en), 0);
    chk("rst_wdata", int'(ifb.w_wdata), 0);
    chk("rst_waddr", int'(ifb.w_addr), 0);
    chk("rst_dv", int'(b_dv), 0);
    chk("rst_dout", int'(b_dout), 0);
    chk("rst_s_busy", int'(s_busy), 0);
    rst_n = 1'b1;

    // 1x1: 0.75 vs 0 -> delta 36, w 256 -> 238
    s_o = 192; s_t = 0; s_h = 128; s_w = 256; s_lr = 256;
    sdq.push_back('{0, 36});
    swq.push_back('{0, 238});
    run_s("single");
    chk("single_mem", s_w, 238);

    // 1x1: w 32760 + 36 clamps to 32767
    s_o = 64; s_t = 256; s_h = 256; s_w = 32760;
    sdq.push_back('{0, -36});
    swq.push_back('{0, 32767});
    run_s("sat");
    chk("sat_mem", s_w, 32767);

    // full pass, start pulsed mid-pass
    b_lr = 16'd200;
    push_pass();
    run_b(221, 1'b1, "full");

    // lr = 0, with o = t / o = 0 / o = ONE neurons
    b_lr = 16'd0;
    for (int k = 0; k < NO; k += 2) t_m[k] = o_m[k];
    o_m[1] = 0;   t_m[1] = 256;
    o_m[3] = 256; t_m[3] = 0;
    for (int k = 0; k < NO; k++) begin
      bdq.push_back('{k, (k % 2 == 0 || k == 1 || k == 3) ? 0
                          : gdelta(o_m[k], t_m[k])});
      for (int j = 0; j < NH; j++)
        bwq.push_back('{k*NH + j, w_m[k*NH + j]});
    end
    run_b(221, 1'b0, "lr0");

    // reset during WR_W of neuron 3
    for (int k = 0; k < NO; k++) begin
      o_m[k] = 30 + 21*k;
      t_m[k] = (k % 2) ? 256 : 0;
    end
    b_lr = 16'd300;
    w35_old = w_m[35];
    w34_new = gw(w_m[34], 300, gdelta(o_m[3], t_m[3]), h_m[4]);
    push_pass();
    b_next_rd = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    while (!(ifb.w_wr_en && ifb.w_addr == 7'd35) && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("rst_reach_addr", int'(ifb.w_addr), 35);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(b_busy), 0);
    chk("arst_wr_en", int'(ifb.w_wr_en), 0);
    chk("arst_rd_en", int'(ifb.w_rd_en), 0);
    chk("arst_waddr", int'(ifb.w_addr), 0);
    chk("arst_wdata", int'(ifb.w_wdata), 0);
    chk("arst_out_addr", int'(b_out_addr), 0);
    bdq.delete();
    bwq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("partial_w34", w_m[34], w34_new);
    chk("partial_w35", w_m[35], w35_old);
    push_pass();
    run_b(221, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backward_propagation.md
Name: backward_propagation

Overview:
Output-layer training engine that runs after forward propagation on one sample. For each output neuron k it computes the error delta from the sigmoid output and the target. It then walks the hidden activations and rewrites every weight w[k][j] in the external weight memory as w - lr*delta*h[j]. It also streams each delta out so a later hidden-layer backprop stage can consume it.

Parameters:
NOUT, 10, output neurons
NHID, 10, hidden neurons (fan-in per output neuron)
DW, 16, signed fixed-point data width
FRAC, 8, fractional bits (Q8.8; 1.0 = 256)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  begin one training pass; sampled only in IDLE
lr  in  DW  learning rate, unsigned Q8.8, held stable while busy
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
out_addr  out  clog2(NOUT)  output-neuron index
out_act  in  DW  sigmoid output o[out_addr], 1-cycle read latency
out_tgt  in  DW  target t[out_addr], 1-cycle read latency
hid_addr  out  clog2(NHID)  hidden index
hid_act  in  DW  h[hid_addr], 1-cycle read latency
w_addr  out  clog2(NOUT*NHID)  weight address = k*NHID + j
w_rd_en  out  1  weight read strobe
w_rdata  in  DW  weight, valid the cycle after w_rd_en
w_wr_en  out  1  weight write strobe
w_wdata  out  DW  updated weight
delta_valid  out  1  delta_out valid strobe
delta_idx  out  clog2(NOUT)  neuron index for delta_out
delta_out  out  DW  delta for neuron delta_idx

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. On reset: state IDLE, k = 0, j = 0, and all outputs 0.
- Reset mid-pass aborts immediately. No write strobe is issued in the reset cycle. A partial update already written stays in memory.
- FSM states: IDLE, FETCH_O, CALC_D, RD_W, WR_W, DONE.
- IDLE: when start = 1, go to FETCH_O with k = 0, and set busy = 1 at that edge.
- FETCH_O (1 cycle): drive out_addr = k. Go to CALC_D.
- CALC_D (1 cycle): out_act and out_tgt are valid. Register delta. Set j = 0. Go to RD_W.
- RD_W (1 cycle): hid_addr = j, w_addr = k*NHID + j, w_rd_en = 1. When j = 0, also pulse delta_valid with delta_idx = k. Go to WR_W.
- WR_W (1 cycle): w_addr unchanged, w_wr_en = 1, w_wdata = new weight.
  - If j < NHID-1: j++ and go to RD_W.
  - Else if k < NOUT-1: k++ and go to FETCH_O.
  - Else go to DONE.
- DONE (1 cycle): done = 1, busy still 1. Go to IDLE, where busy = 0.
- Timing: a pass is NOUT*(2 + 2*NHID) + 1 cycles from the start edge; 221 cycles with defaults. start while busy is ignored.
- Memory access rules: w_rd_en and w_wr_en are never high together. Each address is read exactly once and written exactly once, in ascending order.
- Arithmetic (signed, products at full width, >>> is arithmetic shift with floor):
  - e = o - t (DW+1 bits)
  - p = (o * (ONE - o)) >>> FRAC
  - delta = sat((e * p) >>> FRAC)
  - s = (lr * delta) >>> FRAC
  - dw = (s * h) >>> FRAC
  - w_new = sat(w - dw)
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
- Boundary cases:
  - lr = 0: every weight is rewritten unchanged.
  - o = t, o = 0 or o = ONE: delta = 0.
  - NHID = 1: RD_W/WR_W runs once per neuron.

Decomposition:
- Shared package bp_pkg holds:
  - DW, FRAC, ONE
  - state enum (IDLE..DONE)
  - sat_dw function
  - fixed-point multiply-shift function
  - The forward-propagation stages reuse the same Q format and sat function.
- One sub-module: bp_delta_unit, combinational; inputs o, t; output saturated delta. This lets the delta math be unit-tested against a golden model.

Test Plan:
- Single update: NOUT=1, NHID=1; o=192 (0.75), t=0, lr=256, h=128, w=256 → delta_out=36 and w_wdata=238 at cycle 4 after start. done is on cycle 5.
- Saturation: o=64, t=256, lr=256, h=256, w=32760 → delta_out=-36; w_wdata=32767 (clamped, not wrapped).
- Full pass, defaults, random Q8.8 data → 221 cycles start-to-IDLE. 100 writes to addresses 0..99 in order, each preceded by a read of the same address. Exactly 10 delta_valid pulses, idx 0..9. Weights match the golden model bit-exactly.
- lr=0 and o=t cases → every w_wdata equals the w_rdata of the prior cycle, and delta_out=0 where o=t.
- start pulsed mid-pass → ignored; pass length is unchanged and there is no extra pass afterwards.
- rst_n low during WR_W of neuron 3 → all outputs 0 asynchronously and no further writes. A new start then runs a clean full pass from k=0.
